// File: rtl/dot_sprite_reader.sv
// Dot sprite ROM reader: maps the pixel stream onto sprite ROM rows and emits a
// per-pixel "dot on" flag two cycles later. Position updates take effect at frame_start.
module dot_sprite_reader #(
  parameter int COORD_W    = 10,
  parameter int DOT_WIDTH  = 8,
  parameter int DOT_HEIGHT = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   pos_x,
  input  logic [COORD_W-1:0]   pos_y,
  input  logic                 pos_valid,
  output logic                 pos_ready,
  input  logic                 frame_start,
  input  logic [COORD_W-1:0]   pix_x,
  input  logic [COORD_W-1:0]   pix_y,
  input  logic                 pix_valid,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [DOT_WIDTH-1:0] rom_data,
  output logic                 out_valid,
  output logic                 out_on
);

  localparam int COL_W = (DOT_WIDTH > 1) ? $clog2(DOT_WIDTH) : 1;

  typedef enum logic [1:0] {HIDDEN, HIDDEN_PEND, SHOWN, SHOWN_PEND} state_t;

  state_t state_reg, state_next;
  logic   accept, commit, visible, pending;

  logic [COORD_W-1:0] act_x_reg, act_y_reg, shd_x_reg, shd_y_reg;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= HIDDEN;
    else       state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HIDDEN:      if (accept)      state_next = HIDDEN_PEND;
      SHOWN:       if (accept)      state_next = SHOWN_PEND;
      HIDDEN_PEND: if (frame_start) state_next = SHOWN;
      SHOWN_PEND:  if (frame_start) state_next = SHOWN;
      default:                      state_next = HIDDEN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pos_ready = 1'b0;
    visible   = 1'b0;
    pending   = 1'b0;
    case (state_reg)
      HIDDEN:      pos_ready = 1'b1;
      SHOWN:       begin pos_ready = 1'b1; visible = 1'b1; end
      HIDDEN_PEND: pending = 1'b1;
      SHOWN_PEND:  begin pending = 1'b1; visible = 1'b1; end
      default:     pos_ready = 1'b0;
    endcase
  end

  assign accept = pos_valid & pos_ready;
  // Accept and commit are exclusive: ready is never high while a position is pending.
  assign commit = pending & frame_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      act_x_reg <= '0;
      act_y_reg <= '0;
      shd_x_reg <= '0;
      shd_y_reg <= '0;
    end else if (accept) begin
      shd_x_reg <= pos_x;
      shd_y_reg <= pos_y;
    end else if (commit) begin
      act_x_reg <= shd_x_reg;
      act_y_reg <= shd_y_reg;
    end
  end

  // Extra bit on the far edges keeps a sprite near the screen edge clipped, not wrapped.
  logic [COORD_W:0]   x_end, y_end;
  logic [COL_W-1:0]   dx;
  logic [ADDR_W-1:0]  dy;
  logic               hit;

  assign x_end = {1'b0, act_x_reg} + (COORD_W + 1)'(DOT_WIDTH);
  assign y_end = {1'b0, act_y_reg} + (COORD_W + 1)'(DOT_HEIGHT);
  assign dx    = pix_x[COL_W-1:0]  - act_x_reg[COL_W-1:0];
  assign dy    = pix_y[ADDR_W-1:0] - act_y_reg[ADDR_W-1:0];
  assign hit   = visible & pix_valid
               & (pix_x >= act_x_reg) & ({1'b0, pix_x} < x_end)
               & (pix_y >= act_y_reg) & ({1'b0, pix_y} < y_end);

  logic [ADDR_W-1:0] rom_addr_reg;
  logic [COL_W-1:0]  col_reg;
  logic              hit_q_reg, v_q_reg, out_valid_reg, out_on_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_reg  <= '0;
      col_reg       <= '0;
      hit_q_reg     <= 1'b0;
      v_q_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_on_reg    <= 1'b0;
    end else begin
      rom_addr_reg  <= hit ? dy : '0;
      col_reg       <= COL_W'(DOT_WIDTH - 1) - dx;
      hit_q_reg     <= hit;
      v_q_reg       <= pix_valid;
      out_valid_reg <= v_q_reg;
      out_on_reg    <= hit_q_reg & rom_data[col_reg];
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign out_valid = out_valid_reg;
  assign out_on    = out_on_reg;

endmodule

// File: tb/tb_dot_sprite_reader.sv
// Bench for dot_sprite_reader: directed and random pixel/position traffic checked
// against a coordinate-level sprite model with a two-cycle result delay.
module tb_dot_sprite_reader;

  localparam int COORD_W = 10;
  localparam int DW      = 8;
  localparam int DH      = 8;
  localparam int AW      = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [COORD_W-1:0] pos_x, pos_y, pix_x, pix_y;
  logic               pos_valid, pos_ready, frame_start, pix_valid;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic               out_valid, out_on;

  logic [DW-1:0] rom [DH];
  assign rom_data = rom[rom_addr];

  dot_sprite_reader #(.COORD_W(COORD_W), .DOT_WIDTH(DW), .DOT_HEIGHT(DH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_on(out_on)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model: sprite position bookkeeping in plain integers.
  bit m_shown, m_pend;
  int m_ax, m_ay, m_sx, m_sy;
  bit hold_v, hold_on;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input bit rst, input int px, input int py, input bit pv,
                      input bit fs, input bit qv, input int qx, input int qy);
    bit e_hit, e_on;
    int e_addr;
    reset = rst; pix_x = COORD_W'(px); pix_y = COORD_W'(py); pix_valid = pv;
    frame_start = fs; pos_valid = qv; pos_x = COORD_W'(qx); pos_y = COORD_W'(qy);
    #1;
    if (!rst) chk("pos_ready", 32'(pos_ready), 32'(!m_pend));
    e_hit  = m_shown && pv && px >= m_ax && px < m_ax + DW && py >= m_ay && py < m_ay + DH;
    e_addr = e_hit ? (py - m_ay) : 0;
    e_on   = e_hit && rom[py - m_ay][DW - 1 - (px - m_ax)];
    if (!m_pend && qv) begin
      m_pend = 1; m_sx = qx; m_sy = qy;
    end else if (m_pend && fs) begin
      m_pend = 0; m_shown = 1; m_ax = m_sx; m_ay = m_sy;
    end
    @(posedge clk); #1;
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_on", 32'(out_on), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      m_shown = 0; m_pend = 0; m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0;
      hold_v = 0; hold_on = 0;
    end else begin
      chk($sformatf("out_valid(%0d,%0d)", px, py), 32'(out_valid), 32'(hold_v));
      chk($sformatf("out_on(%0d,%0d)", px, py), 32'(out_on), 32'(hold_on));
      chk($sformatf("rom_addr(%0d,%0d)", px, py), 32'(rom_addr), 32'(e_addr));
      hold_v = pv; hold_on = e_on;
    end
  endtask

  task automatic pix(input int px, input int py);
    step(0, px, py, 1, 0, 0, 0, 0);
  endtask

  task automatic load(input int qx, input int qy);
    step(0, 0, 0, 0, 0, 1, qx, qy);
  endtask

  task automatic fstart();
    step(0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) pix(x, y);
  endtask

  initial begin
    rom[0] = 8'b00111100; rom[1] = 8'b01111110; rom[2] = 8'b11111111; rom[3] = 8'b11111111;
    rom[4] = 8'b11111111; rom[5] = 8'b11111111; rom[6] = 8'b01111110; rom[7] = 8'b00111100;

    // Reset and unloaded scan
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    scan(0, 15, 0, 15);

    // Load (100,50); second request must be ignored while pending
    load(100, 50);
    load(200, 200);
    pix(100, 50);
    fstart();
    scan(98, 109, 49, 58);
    pix(99, 50); pix(108, 50); pix(100, 58);

    // Request and frame_start together: old position stays until the next frame_start
    step(0, 0, 0, 0, 1, 1, 300, 300);
    scan(99, 103, 50, 51);
    scan(300, 303, 300, 300);
    fstart();
    scan(300, 308, 300, 302);
    pix(100, 52);

    // Bottom-right edge: clipped, never wrapped
    load(1020, 1020);
    fstart();
    scan(1016, 1023, 1016, 1023);
    scan(0, 3, 0, 3);
    pix(0, 0); pix(2, 2);

    // Reset while pending with pixels in flight
    load(10, 10);
    pix(1021, 1021); pix(1022, 1022);
    step(1, 1023, 1023, 1, 1, 0, 0, 0);
    pix(12, 12);
    scan(8, 19, 8, 19);
    fstart();
    scan(8, 12, 8, 12);

    // Random traffic with gaps, loads and frame starts
    for (int i = 0; i < 3000; i++) begin
      step(0, $urandom_range(0, 48), $urandom_range(0, 48), ($urandom % 4) != 0,
           ($urandom % 16) == 0, ($urandom % 8) == 0,
           $urandom_range(0, 40), $urandom_range(0, 40));
    end
    for (int i = 0; i < 400; i++) begin
      step(0, $urandom_range(1000, 1023), $urandom_range(1000, 1023), $urandom % 2,
           ($urandom % 16) == 0, ($urandom % 8) == 0,
           $urandom_range(1010, 1023), $urandom_range(1010, 1023));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
